// File: rtl/fwd_mux_hold_pkg.sv
// Shared definitions for the forwarding and pipeline-register blocks:
// the two-state hold FSM encoding and a constant clog2 helper.
package fwd_mux_hold_pkg;

    typedef enum logic {
        PASS = 1'b0,
        HELD = 1'b1
    } fwd_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_mux_comb.sv
// Purely combinational NUM_IN-to-1 selector. An out-of-range select
// falls back to the last input and raises sel_bad.
module fwd_mux_comb
    import fwd_mux_hold_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] In,
    input  logic [SEL_W-1:0]        Sel,
    output logic [WIDTH-1:0]        sel_val,
    output logic                    sel_bad
);

    logic [WIDTH-1:0] in_arr [NUM_IN];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
            assign in_arr[gi] = In[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        sel_val = in_arr[NUM_IN-1];
        sel_bad = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (Sel == SEL_W'(k)) begin
                sel_val = in_arr[k];
                sel_bad = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fwd_mux_hold.sv
// Registered forwarding mux with a one-entry stall capture buffer: the operand
// seen on the first stall cycle is replayed when the stall releases.
module fwd_mux_hold
    import fwd_mux_hold_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NUM_IN*WIDTH-1:0] In,
    input  logic [SEL_W-1:0]        Sel,
    input  logic                    Valid_in,
    input  logic                    Stall,
    input  logic                    Flush,
    output logic [WIDTH-1:0]        Out,
    output logic                    Valid_out,
    output logic                    Sel_err
);

    generate
        if (NUM_IN < 2) begin : g_bad_num_in
            $error("fwd_mux_hold: NUM_IN must be at least 2");
        end
        if (SEL_W < clog2(NUM_IN)) begin : g_bad_sel_w
            $error("fwd_mux_hold: SEL_W too narrow for NUM_IN");
        end
    endgenerate

    logic [WIDTH-1:0] sel_val;
    logic             sel_bad;
    logic             sel_err_n;

    fwd_mux_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_comb (
        .In      (In),
        .Sel     (Sel),
        .sel_val (sel_val),
        .sel_bad (sel_bad)
    );

    assign sel_err_n = sel_bad & Valid_in;

    fwd_state_e       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             hold_v_q, hold_v_d;
    logic             hold_err_q, hold_err_d;

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        valid_d     = valid_q;
        err_d       = err_q;
        hold_data_d = hold_data_q;
        hold_v_d    = hold_v_q;
        hold_err_d  = hold_err_q;

        if (Flush) begin
            state_d     = PASS;
            out_d       = '0;
            valid_d     = 1'b0;
            err_d       = 1'b0;
            hold_data_d = '0;
            hold_v_d    = 1'b0;
            hold_err_d  = 1'b0;
        end else begin
            case (state_q)
                PASS: begin
                    if (Stall) begin
                        // Capture even an invalid operand so the replay mirrors the stall cycle.
                        hold_data_d = sel_val;
                        hold_v_d    = Valid_in;
                        hold_err_d  = sel_err_n;
                        state_d     = HELD;
                    end else begin
                        out_d   = sel_val;
                        valid_d = Valid_in;
                        err_d   = sel_err_n;
                    end
                end
                HELD: begin
                    if (!Stall) begin
                        out_d       = hold_data_q;
                        valid_d     = hold_v_q;
                        err_d       = hold_err_q;
                        hold_data_d = '0;
                        hold_v_d    = 1'b0;
                        hold_err_d  = 1'b0;
                        state_d     = PASS;
                    end
                end
                default: state_d = PASS;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= PASS;
            out_q       <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            hold_data_q <= '0;
            hold_v_q    <= 1'b0;
            hold_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            hold_data_q <= hold_data_d;
            hold_v_q    <= hold_v_d;
            hold_err_q  <= hold_err_d;
        end
    end

    assign Out       = out_q;
    assign Valid_out = valid_q;
    assign Sel_err   = err_q;

endmodule

// File: tb/tb_fwd_mux_hold.sv
// Directed bench for fwd_mux_hold at the default 32x3 configuration and an 8x5 one.
module tb_fwd_mux_hold;

    logic Clk;
    logic Rst;
    logic Flush;

    // 32-bit, 3-input instance
    logic [95:0] a_in;
    logic [1:0]  a_sel;
    logic        a_vin, a_stall;
    logic [31:0] a_out;
    logic        a_vout, a_err;

    // 8-bit, 5-input instance
    logic [39:0] b_in;
    logic [2:0]  b_sel;
    logic        b_vin, b_stall;
    logic [7:0]  b_out;
    logic        b_vout, b_err;

    int vectors;
    int miscompares;

    fwd_mux_hold #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u_a (
        .Clk(Clk), .Rst(Rst), .In(a_in), .Sel(a_sel), .Valid_in(a_vin),
        .Stall(a_stall), .Flush(Flush), .Out(a_out), .Valid_out(a_vout),
        .Sel_err(a_err)
    );

    fwd_mux_hold #(.WIDTH(8), .NUM_IN(5), .SEL_W(3)) u_b (
        .Clk(Clk), .Rst(Rst), .In(b_in), .Sel(b_sel), .Valid_in(b_vin),
        .Stall(b_stall), .Flush(1'b0), .Out(b_out), .Valid_out(b_vout),
        .Sel_err(b_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [31:0] o, input logic v, input logic e);
        chk({tag, ".out"}, a_out, o);
        chk({tag, ".vld"}, {31'd0, a_vout}, {31'd0, v});
        chk({tag, ".err"}, {31'd0, a_err}, {31'd0, e});
    endtask

    task automatic chk_b(input string tag, input logic [7:0] o, input logic v, input logic e);
        chk({tag, ".out"}, {24'd0, b_out}, {24'd0, o});
        chk({tag, ".vld"}, {31'd0, b_vout}, {31'd0, v});
        chk({tag, ".err"}, {31'd0, b_err}, {31'd0, e});
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        Rst = 1'b1; Flush = 1'b0;
        a_in = {32'h33, 32'h22, 32'h11}; a_sel = 2'd1; a_vin = 1'b1; a_stall = 1'b0;
        b_in = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10}; b_sel = 3'd4; b_vin = 1'b1; b_stall = 1'b0;

        // Reset with live nonzero inputs
        tick(); tick();
        chk_a("rst_a", 32'h0, 1'b0, 1'b0);
        chk("rst_a.state", {31'd0, u_a.state_q}, 32'd0);
        chk_b("rst_b", 8'h00, 1'b0, 1'b0);
        $display("vec reset: a_out=%h b_out=%h", a_out, b_out);
        Rst = 1'b0;

        // Normal select, one-cycle latency
        a_sel = 2'd0; tick(); chk_a("sel0", 32'h11, 1'b1, 1'b0);
        $display("vec sel0: out=%h", a_out);
        a_sel = 2'd1; tick(); chk_a("sel1", 32'h22, 1'b1, 1'b0);
        $display("vec sel1: out=%h", a_out);
        a_sel = 2'd2; tick(); chk_a("sel2", 32'h33, 1'b1, 1'b0);
        $display("vec sel2: out=%h", a_out);

        // Out-of-range select
        a_sel = 2'd3; a_vin = 1'b1; tick(); chk_a("oor_v1", 32'h33, 1'b1, 1'b1);
        $display("vec oor valid: out=%h err=%b", a_out, a_err);
        a_vin = 1'b0; tick(); chk_a("oor_v0", 32'h33, 1'b0, 1'b0);
        $display("vec oor invalid: out=%h err=%b", a_out, a_err);

        // Stall capture and replay
        a_sel = 2'd0; a_vin = 1'b1; tick(); chk_a("pre_stall", 32'h11, 1'b1, 1'b0);
        a_sel = 2'd1; a_in[63:32] = 32'hAAAA; a_stall = 1'b1;
        tick(); chk_a("stall1", 32'h11, 1'b1, 1'b0);
        chk("stall1.state", {31'd0, u_a.state_q}, 32'd1);
        a_in[63:32] = 32'hBBBB;
        tick(); chk_a("stall2", 32'h11, 1'b1, 1'b0);
        tick(); chk_a("stall3", 32'h11, 1'b1, 1'b0);
        a_stall = 1'b0;
        tick(); chk_a("replay", 32'hAAAA, 1'b1, 1'b0);
        chk("replay.state", {31'd0, u_a.state_q}, 32'd0);
        $display("vec stall replay: out=%h", a_out);
        tick(); chk_a("post_replay", 32'hBBBB, 1'b1, 1'b0);

        // Flush overrides stall in HELD; no replay afterwards
        a_sel = 2'd2; a_stall = 1'b1;
        tick(); chk_a("flush_pre", 32'hBBBB, 1'b1, 1'b0);
        a_in[95:64] = 32'h44; Flush = 1'b1;
        tick(); chk_a("flush", 32'h0, 1'b0, 1'b0);
        chk("flush.state", {31'd0, u_a.state_q}, 32'd0);
        Flush = 1'b0; a_stall = 1'b0;
        tick(); chk_a("no_replay", 32'h44, 1'b1, 1'b0);
        $display("vec flush: out=%h", a_out);

        // Captured out-of-range flag is replayed
        a_sel = 2'd3; a_stall = 1'b1;
        tick(); chk_a("err_cap", 32'h44, 1'b1, 1'b0);
        a_sel = 2'd0; a_stall = 1'b0;
        tick(); chk_a("err_replay", 32'h44, 1'b1, 1'b1);
        $display("vec err replay: out=%h err=%b", a_out, a_err);

        // Captured invalid operand replays as invalid
        a_vin = 1'b0; a_stall = 1'b1;
        tick(); a_vin = 1'b1; a_stall = 1'b0;
        tick(); chk_a("inv_replay", 32'h11, 1'b0, 1'b0);
        $display("vec invalid replay: out=%h vld=%b", a_out, a_vout);

        // 8-bit, 5-input configuration
        b_sel = 3'd4; tick(); chk_b("b_sel4", 8'h14, 1'b1, 1'b0);
        $display("vec b sel4: out=%h", b_out);
        for (int s = 5; s < 8; s++) begin
            b_sel = 3'(s);
            tick(); chk_b("b_oor", 8'h14, 1'b1, 1'b1);
            $display("vec b sel%0d: out=%h err=%b", s, b_out, b_err);
        end
        b_sel = 3'd2; tick(); chk_b("b_sel2", 8'h12, 1'b1, 1'b0);
        b_sel = 3'd1; b_in[15:8] = 8'hAA; b_stall = 1'b1;
        tick(); chk_b("b_stall1", 8'h12, 1'b1, 1'b0);
        chk("b_stall1.state", {31'd0, u_b.state_q}, 32'd1);
        b_in[15:8] = 8'hBB;
        tick(); chk_b("b_stall2", 8'h12, 1'b1, 1'b0);
        tick(); chk_b("b_stall3", 8'h12, 1'b1, 1'b0);
        b_stall = 1'b0;
        tick(); chk_b("b_replay", 8'hAA, 1'b1, 1'b0);
        $display("vec b stall replay: out=%h", b_out);
        tick(); chk_b("b_post", 8'hBB, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
